seg7_scan_driver: RTL and testbench

SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

---
 rtl/seg7_pkg.sv | 36 +++
 rtl/seg7_hex_decode.sv | 17 +
 rtl/seg7_scan_driver.sv | 134 +++++++++++++
 tb/tb_seg7_scan_driver.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: segment bit order and active-low glyph table.
package seg7_pkg;

    localparam int unsigned SEG_A = 0;
    localparam int unsigned SEG_B = 1;
    localparam int unsigned SEG_C = 2;
    localparam int unsigned SEG_D = 3;
    localparam int unsigned SEG_E = 4;
    localparam int unsigned SEG_F = 5;
    localparam int unsigned SEG_G = 6;

    // Bit 6..0 = g,f,e,d,c,b,a; a 0 lights the segment.
    localparam logic [6:0] GLYPH_0    = 7'b1000000;
    localparam logic [6:0] GLYPH_1    = 7'b1111001;
    localparam logic [6:0] GLYPH_2    = 7'b0100100;
    localparam logic [6:0] GLYPH_3    = 7'b0110000;
    localparam logic [6:0] GLYPH_4    = 7'b0011001;
    localparam logic [6:0] GLYPH_5    = 7'b0010010;
    localparam logic [6:0] GLYPH_6    = 7'b0000010;
    localparam logic [6:0] GLYPH_7    = 7'b1111000;
    localparam logic [6:0] GLYPH_8    = 7'b0000000;
    localparam logic [6:0] GLYPH_9    = 7'b0010000;
    localparam logic [6:0] GLYPH_A    = 7'b0001000;
    localparam logic [6:0] GLYPH_B    = 7'b0000011;
    localparam logic [6:0] GLYPH_C    = 7'b1000110;
    localparam logic [6:0] GLYPH_D    = 7'b0100001;
    localparam logic [6:0] GLYPH_E    = 7'b0000110;
    localparam logic [6:0] GLYPH_F    = 7'b0001110;
    localparam logic [6:0] GLYPH_DARK = 7'b1111111;

    localparam logic [6:0] GLYPHS [16] = '{
        GLYPH_0, GLYPH_1, GLYPH_2, GLYPH_3, GLYPH_4, GLYPH_5, GLYPH_6, GLYPH_7,
        GLYPH_8, GLYPH_9, GLYPH_A, GLYPH_B, GLYPH_C, GLYPH_D, GLYPH_E, GLYPH_F
    };

endpackage

// File: rtl/seg7_hex_decode.sv
// Nibble to active-low glyph; decimal mode shows 10-15 dark.
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       hex_mode,
    input  logic       dark,
    output logic [6:0] glyph
);

    always_comb begin
        glyph = GLYPH_DARK;
        if (!dark && (hex_mode || nibble <= 4'd9))
            glyph = GLYPHS[nibble];
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed seven-segment scan driver with frame-aligned double-buffered settings.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int unsigned DIGITS     = 4,
    parameter int unsigned SCAN_DIV   = 50000,
    parameter bit          ACTIVE_LOW = 1'b1
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     blank_mask,
    input  logic                  lz_suppress,
    input  logic                  hex_mode,
    output logic [6:0]            seg,
    output logic [DIGITS-1:0]     an,
    output logic                  pending,
    output logic                  frame_done
);

    localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

    logic [PW-1:0]         pre;
    logic [IW-1:0]         idx;
    logic [4*DIGITS-1:0]   act_value, pnd_value, src_value, eff_value;
    logic [DIGITS-1:0]     act_blank, pnd_blank, src_blank, eff_blank;
    logic                  act_lz, pnd_lz, src_lz, eff_lz;
    logic                  act_hex, pnd_hex, src_hex, eff_hex;

    logic                  tick, boundary, commit;
    logic [IW-1:0]         nidx;
    logic                  upper_zero, dark;
    logic [3:0]            nibble;
    logic [6:0]            glyph;
    logic [DIGITS-1:0]     an_sel;

    assign tick     = (pre == PRE_LAST);
    assign boundary = tick && (idx == IDX_LAST);
    assign commit   = boundary && (load || pending);
    assign nidx     = (idx == IDX_LAST) ? '0 : idx + 1'b1;

    always_comb begin
        src_value = act_value;
        src_blank = act_blank;
        src_lz    = act_lz;
        src_hex   = act_hex;
        if (load) begin
            src_value = value;
            src_blank = blank_mask;
            src_lz    = lz_suppress;
            src_hex   = hex_mode;
        end else if (pending) begin
            src_value = pnd_value;
            src_blank = pnd_blank;
            src_lz    = pnd_lz;
            src_hex   = pnd_hex;
        end
    end

    // Digit 0 is registered on the same edge that commits, so decode from the incoming settings.
    always_comb begin
        eff_value = commit ? src_value : act_value;
        eff_blank = commit ? src_blank : act_blank;
        eff_lz    = commit ? src_lz    : act_lz;
        eff_hex   = commit ? src_hex   : act_hex;
    end

    always_comb begin
        nibble     = eff_value[4*32'(nidx) +: 4];
        upper_zero = 1'b1;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (i >= 32'(nidx) && eff_value[4*i +: 4] != 4'h0)
                upper_zero = 1'b0;
        end
        dark = eff_blank[nidx] || (eff_lz && (nidx != '0) && upper_zero);
        an_sel = '0;
        an_sel[nidx] = 1'b1;
    end

    seg7_hex_decode u_decode (
        .nibble   (nibble),
        .hex_mode (eff_hex),
        .dark     (dark),
        .glyph    (glyph)
    );

    always_ff @(posedge clock) begin
        if (!resetn) begin
            pre        <= '0;
            idx        <= IDX_LAST;
            act_value  <= '0;
            act_blank  <= '0;
            act_lz     <= 1'b0;
            act_hex    <= 1'b0;
            pnd_value  <= '0;
            pnd_blank  <= '0;
            pnd_lz     <= 1'b0;
            pnd_hex    <= 1'b0;
            pending    <= 1'b0;
            frame_done <= 1'b0;
            seg        <= {7{ACTIVE_LOW}};
            an         <= {DIGITS{ACTIVE_LOW}};
        end else begin
            pre        <= tick ? '0 : pre + 1'b1;
            frame_done <= boundary;
            if (tick) begin
                idx <= nidx;
                seg <= glyph ^ {7{~ACTIVE_LOW}};
                an  <= ~an_sel ^ {DIGITS{~ACTIVE_LOW}};
            end
            if (commit) begin
                act_value <= src_value;
                act_blank <= src_blank;
                act_lz    <= src_lz;
                act_hex   <= src_hex;
            end
            if (load) begin
                pnd_value <= value;
                pnd_blank <= blank_mask;
                pnd_lz    <= lz_suppress;
                pnd_hex   <= hex_mode;
            end
            if (boundary)
                pending <= 1'b0;
            else if (load)
                pending <= 1'b1;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench: per-frame glyph vectors plus double-buffer and reset corner cases.
module tb_seg7_scan_driver;

    logic        clock = 1'b0;
    logic        resetn;
    logic        load;
    logic [15:0] value;
    logic [3:0]  blank_mask;
    logic        lz_suppress;
    logic        hex_mode;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        pending;
    logic        frame_done;

    seg7_scan_driver #(
        .DIGITS     (4),
        .SCAN_DIV   (4),
        .ACTIVE_LOW (1'b1)
    ) dut (
        .clock       (clock),
        .resetn      (resetn),
        .load        (load),
        .value       (value),
        .blank_mask  (blank_mask),
        .lz_suppress (lz_suppress),
        .hex_mode    (hex_mode),
        .seg         (seg),
        .an          (an),
        .pending     (pending),
        .frame_done  (frame_done)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [15:0]     value;
        logic [3:0]      blank;
        logic            lz;
        logic            hex;
        logic [3:0][6:0] exp_seg;   // [3] = digit 3 ... [0] = digit 0
    } vec_t;

    typedef struct {
        logic [6:0] seg;
        logic [3:0] an;
    } slot_t;

    vec_t  vecs [8];
    slot_t sb [$];
    int    checks = 0;
    int    errors = 0;
    int    n;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_frame(input int max, output int steps);
        steps = 0;
        while (!frame_done && steps < max) begin
            step();
            steps++;
        end
        checks++;
        if (!frame_done) begin
            errors++;
            $display("FAIL frame_timeout: got no frame_done expected pulse within %0d cycles", max);
        end
    endtask

    task automatic push_frame(input logic [3:0][6:0] exp_seg);
        slot_t s;
        logic [3:0] one;
        for (int unsigned k = 0; k < 4; k++) begin
            one   = 4'b0001 << k;
            s.seg = exp_seg[k];
            s.an  = 4'b1111 ^ one;
            sb.push_back(s);
        end
    endtask

    // Call at the sample point just after a boundary; ends one cycle before the next one.
    task automatic check_frame(input string tag);
        slot_t e;
        for (int unsigned k = 0; k < 4; k++) begin
            if (sb.size() == 0) begin
                chk($sformatf("%s_sb_empty", tag), 32'(sb.size()), 32'd4 - k);
            end else begin
                e = sb.pop_front();
                for (int unsigned c = 0; c < 4; c++) begin
                    chk($sformatf("%s_d%0d_c%0d_seg", tag, k, c), 32'(seg), 32'(e.seg));
                    chk($sformatf("%s_d%0d_c%0d_an", tag, k, c), 32'(an), 32'(e.an));
                    if (!(k == 3 && c == 3))
                        step();
                end
            end
        end
    endtask

    task automatic drive(input logic [15:0] v, input logic [3:0] b, input logic lz, input logic hx);
        load        = 1'b1;
        value       = v;
        blank_mask  = b;
        lz_suppress = lz;
        hex_mode    = hx;
    endtask

    initial begin
        vecs[0] = '{16'h1234, 4'b0000, 1'b0, 1'b1, {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001}};
        vecs[1] = '{16'h00A7, 4'b0000, 1'b1, 1'b0, {7'b1111111, 7'b1111111, 7'b1111111, 7'b1111000}};
        vecs[2] = '{16'h0000, 4'b0000, 1'b1, 1'b1, {7'b1111111, 7'b1111111, 7'b1111111, 7'b1000000}};
        vecs[3] = '{16'hBEEF, 4'b0000, 1'b0, 1'b1, {7'b0000011, 7'b0000110, 7'b0000110, 7'b0001110}};
        vecs[4] = '{16'h5678, 4'b0101, 1'b0, 1'b1, {7'b0010010, 7'b1111111, 7'b1111000, 7'b1111111}};
        vecs[5] = '{16'h0906, 4'b0000, 1'b1, 1'b0, {7'b1111111, 7'b0010000, 7'b1000000, 7'b0000010}};
        vecs[6] = '{16'hCAD8, 4'b0000, 1'b0, 1'b1, {7'b1000110, 7'b0001000, 7'b0100001, 7'b0000000}};
        vecs[7] = '{16'h3A00, 4'b0000, 1'b1, 1'b0, {7'b0110000, 7'b1111111, 7'b1000000, 7'b1000000}};

        // Reset with a load held high: the load must be ignored.
        resetn = 1'b0;
        drive(16'h8888, 4'b0000, 1'b0, 1'b1);
        repeat (3) step();
        chk("rst_an", 32'(an), 32'hF);
        chk("rst_seg", 32'(seg), 32'h7F);
        chk("rst_pending", 32'(pending), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        load   = 1'b0;
        resetn = 1'b1;
        wait_frame(40, n);
        chk("first_tick_latency", 32'(n), 32'd4);
        chk("first_seg", 32'(seg), 32'h40);
        chk("first_an", 32'(an), 32'hE);
        chk("first_pending", 32'(pending), 32'd0);
        step();
        chk("frame_done_pulse", 32'(frame_done), 32'd0);

        for (int i = 0; i < 8; i++) begin
            step();
            drive(vecs[i].value, vecs[i].blank, vecs[i].lz, vecs[i].hex);
            push_frame(vecs[i].exp_seg);
            step();
            load = 1'b0;
            chk($sformatf("v%0d_pending_set", i), 32'(pending), 32'd1);
            wait_frame(40, n);
            chk($sformatf("v%0d_pending_clr", i), 32'(pending), 32'd0);
            check_frame($sformatf("v%0d", i));
        end

        // Two loads in one frame: the last one wins.
        step();
        drive(16'h1111, 4'b0000, 1'b0, 1'b1);
        step();
        load = 1'b0;
        chk("ovr_pending1", 32'(pending), 32'd1);
        step();
        drive(16'h2222, 4'b0000, 1'b0, 1'b1);
        push_frame({4{7'b0100100}});
        step();
        load = 1'b0;
        chk("ovr_pending2", 32'(pending), 32'd1);
        wait_frame(40, n);
        chk("ovr_pending_clr", 32'(pending), 32'd0);
        check_frame("ovr");

        // Load on the boundary edge itself commits straight to the display.
        drive(16'h9876, 4'b0000, 1'b0, 1'b1);
        push_frame({7'b0010000, 7'b0000000, 7'b1111000, 7'b0000010});
        step();
        load = 1'b0;
        chk("bnd_frame_done", 32'(frame_done), 32'd1);
        chk("bnd_pending", 32'(pending), 32'd0);
        check_frame("bnd");
        chk("bnd_pending_end", 32'(pending), 32'd0);

        // Reset mid-frame discards a pending setting.
        step();
        drive(16'h4444, 4'b0000, 1'b0, 1'b1);
        step();
        load = 1'b0;
        chk("mid_pending", 32'(pending), 32'd1);
        step();
        resetn = 1'b0;
        step();
        chk("mid_rst_an", 32'(an), 32'hF);
        chk("mid_rst_seg", 32'(seg), 32'h7F);
        chk("mid_rst_pending", 32'(pending), 32'd0);
        resetn = 1'b1;
        wait_frame(40, n);
        chk("mid_latency", 32'(n), 32'd4);
        chk("mid_seg", 32'(seg), 32'h40);
        chk("mid_an", 32'(an), 32'hE);
        chk("mid_pending_after", 32'(pending), 32'd0);

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
